mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: memory address, read/write enables, write data, rd address/enable/format and rd data.
- Drives a single-port data-memory request/acknowledge interface, applies byte-lane steering and load sign/zero extension, and registers the writeback bundle for the register file.
- Asserts halt_o back to fetch/decode/execute while a memory transaction is outstanding.

---
 rtl/mem_access_if.sv | 23 ++
 rtl/mem_access.sv | 192 +++++++++++++++++++
 tb/tb_mem_access.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and a single-port data memory (slave).
interface mem_access_if #(
  parameter int DW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: issues data-memory requests, steers store lanes, formats loads
// and registers the writeback bundle. Optional MEM_MISALIGN_CHECK_EN rejects misaligned accesses.
module mem_access #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk_i,
  input  logic           resetn_i,
  input  logic [DW-1:0]  mem_addr_i,
  input  logic           mem_read_en_i,
  input  logic           mem_write_en_i,
  input  logic [2:0]     mem_write_fmt_i,
  input  logic [DW-1:0]  mem_write_data_i,
  input  logic [RAW-1:0] rd_addr_i,
  input  logic           rd_write_en_i,
  input  logic [4:0]     rd_write_fmt_i,
  input  logic [DW-1:0]  rd_data_i,
  mem_access_if.master   dmem,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic           misalign_o,
`endif
  output logic           halt_o,
  output logic [RAW-1:0] wb_rd_addr_o,
  output logic           wb_rd_write_en_o,
  output logic [DW-1:0]  wb_rd_data_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t         state_q, state_d;
  logic           we_q, we_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [3:0]     be_q, be_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [1:0]     lane_q, lane_d;
  logic [4:0]     ldfmt_q, ldfmt_d;
  logic [RAW-1:0] rdl_q, rdl_d;
  logic [RAW-1:0] wb_addr_q, wb_addr_d;
  logic           wb_en_q, wb_en_d;
  logic [DW-1:0]  wb_data_q, wb_data_d;
  logic           reject;
`ifdef MEM_MISALIGN_CHECK_EN
  logic           misalign_q, misalign_d;
  logic           is_wr, is_rd;
`endif

  function automatic logic [3:0] store_be(input logic [2:0] fmt, input logic [1:0] a);
    case (fmt)
      3'b001:  store_be = 4'b0001 << a;
      3'b010:  store_be = a[1] ? 4'b1100 : 4'b0011;
      3'b100:  store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [DW-1:0] store_data(input logic [2:0] fmt, input logic [DW-1:0] d);
    case (fmt)
      3'b001:  store_data = {(DW/8){d[7:0]}};
      3'b010:  store_data = {(DW/16){d[15:0]}};
      3'b100:  store_data = d;
      default: store_data = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] load_fmt(input logic [DW-1:0] rdata, input logic [1:0] a,
                                             input logic [4:0] fmt);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[16 +: 16] : rdata[0 +: 16];
    case (fmt)
      5'b00001: load_fmt = {{(DW-8){b[7]}}, b};
      5'b00010: load_fmt = {{(DW-16){h[15]}}, h};
      5'b00100: load_fmt = rdata;
      5'b01000: load_fmt = {{(DW-8){1'b0}}, b};
      5'b10000: load_fmt = {{(DW-16){1'b0}}, h};
      default:  load_fmt = '0;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  // A simultaneous read+write is treated as a write, so only the winning format is checked.
  assign is_wr  = mem_write_en_i;
  assign is_rd  = mem_read_en_i & ~mem_write_en_i;
  assign reject = (is_wr & ((mem_write_fmt_i[1] & mem_addr_i[0]) |
                            (mem_write_fmt_i[2] & (|mem_addr_i[1:0])))) |
                  (is_rd & (((rd_write_fmt_i[1] | rd_write_fmt_i[4]) & mem_addr_i[0]) |
                            (rd_write_fmt_i[2] & (|mem_addr_i[1:0]))));
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    lane_d    = lane_q;
    ldfmt_d   = ldfmt_q;
    rdl_d     = rdl_q;
    wb_addr_d = wb_addr_q;
    wb_en_d   = 1'b0;
    wb_data_d = wb_data_q;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_read_en_i || mem_write_en_i) begin
          if (reject) begin
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            state_d = ACCESS;
            we_d    = mem_write_en_i;
            addr_d  = {mem_addr_i[DW-1:2], 2'b00};
            lane_d  = mem_addr_i[1:0];
            be_d    = mem_write_en_i ? store_be(mem_write_fmt_i, mem_addr_i[1:0]) : 4'b1111;
            wdata_d = mem_write_en_i ? store_data(mem_write_fmt_i, mem_write_data_i) : '0;
            ldfmt_d = rd_write_fmt_i;
            rdl_d   = rd_addr_i;
          end
        end else begin
          wb_addr_d = rd_addr_i;
          wb_data_d = rd_data_i;
          wb_en_d   = rd_write_en_i && (rd_addr_i != '0);
        end
      end
      ACCESS: begin
        if (dmem.dmem_ack) begin
          state_d = IDLE;
          if (!we_q) begin
            wb_addr_d = rdl_q;
            wb_data_d = load_fmt(dmem.dmem_rdata, lane_q, ldfmt_q);
            wb_en_d   = (rdl_q != '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      lane_q    <= '0;
      ldfmt_q   <= '0;
      rdl_q     <= '0;
      wb_addr_q <= '0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      lane_q    <= lane_d;
      ldfmt_q   <= ldfmt_d;
      rdl_q     <= rdl_d;
      wb_addr_q <= wb_addr_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign dmem.dmem_req   = (state_q == ACCESS);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign halt_o           = (state_q == ACCESS);
  assign wb_rd_addr_o     = wb_addr_q;
  assign wb_rd_write_en_o = wb_en_q;
  assign wb_rd_data_o     = wb_data_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; covers misalign rejection when
// MEM_MISALIGN_CHECK_EN is defined and in-word wrapping otherwise.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [2:0]  mem_wfmt;
  logic [31:0] mem_wdata;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [4:0]  rd_fmt;
  logic [31:0] rd_data;
  logic        halt;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif
  int checks = 0;
  int failures = 0;

  mem_access_if #(.DW(32)) dmem_if ();

  mem_access #(.DW(32), .RAW(5)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .mem_addr_i(mem_addr), .mem_read_en_i(mem_rd), .mem_write_en_i(mem_wr),
    .mem_write_fmt_i(mem_wfmt), .mem_write_data_i(mem_wdata),
    .rd_addr_i(rd_addr), .rd_write_en_i(rd_we), .rd_write_fmt_i(rd_fmt), .rd_data_i(rd_data),
    .dmem(dmem_if),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign_o(misalign),
`endif
    .halt_o(halt), .wb_rd_addr_o(wb_addr), .wb_rd_write_en_o(wb_en), .wb_rd_data_o(wb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_addr = '0; mem_rd = 0; mem_wr = 0; mem_wfmt = '0; mem_wdata = '0;
    rd_addr = '0; rd_we = 0; rd_fmt = '0; rd_data = '0;
    dmem_if.dmem_ack = 0; dmem_if.dmem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    tick(); tick();
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt got=%b exp=0", halt); end
    checks++; if (dmem_if.dmem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", dmem_if.dmem_req); end
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rst_wb_en got=%b exp=0", wb_en); end
    checks++; if (dmem_if.dmem_be !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", dmem_if.dmem_be); end
    checks++; if (dmem_if.dmem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", dmem_if.dmem_addr); end
    checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
`ifdef MEM_MISALIGN_CHECK_EN
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
`endif
    resetn = 1;
  endtask

  task automatic test_passthrough();
    rd_addr = 5; rd_data = 32'h1234; rd_we = 1;
    tick();
    checks++; if (wb_addr !== 5'd5) begin failures++; $display("FAIL pt_addr got=%0d exp=5", wb_addr); end
    checks++; if (wb_data !== 32'h1234) begin failures++; $display("FAIL pt_data got=%h exp=00001234", wb_data); end
    checks++; if (wb_en !== 1'b1) begin failures++; $display("FAIL pt_en got=%b exp=1", wb_en); end
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL pt_halt got=%b exp=0", halt); end
    rd_addr = 0; rd_data = 32'h77; rd_we = 1;
    tick();
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL pt_x0_en got=%b exp=0", wb_en); end
    idle_inputs();
  endtask

  task automatic test_load_byte();
    mem_addr = 32'h103; mem_rd = 1; rd_fmt = 5'b00001; rd_addr = 7;
    tick();
    // upstream keeps garbage on its outputs while halted; it must be ignored
    mem_addr = 32'hFFFF_FFFF; rd_addr = 1; rd_fmt = 5'b00100;
    checks++; if (dmem_if.dmem_req !== 1'b1) begin failures++; $display("FAIL lb_req got=%b exp=1", dmem_if.dmem_req); end
    checks++; if (dmem_if.dmem_we !== 1'b0) begin failures++; $display("FAIL lb_we got=%b exp=0", dmem_if.dmem_we); end
    checks++; if (dmem_if.dmem_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", dmem_if.dmem_addr); end
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL lb_halt1 got=%b exp=1", halt); end
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL lb_wb_en_wait got=%b exp=0", wb_en); end
    tick();
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL lb_halt2 got=%b exp=1", halt); end
    checks++; if (dmem_if.dmem_addr !== 32'h100) begin failures++; $display("FAIL lb_addr_hold got=%h exp=00000100", dmem_if.dmem_addr); end
    tick();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h80FF_0000;
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL lb_halt3 got=%b exp=1", halt); end
    tick();
    idle_inputs();
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL lb_halt_end got=%b exp=0", halt); end
    checks++; if (dmem_if.dmem_req !== 1'b0) begin failures++; $display("FAIL lb_req_end got=%b exp=0", dmem_if.dmem_req); end
    checks++; if (wb_en !== 1'b1) begin failures++; $display("FAIL lb_wb_en got=%b exp=1", wb_en); end
    checks++; if (wb_addr !== 5'd7) begin failures++; $display("FAIL lb_wb_addr got=%0d exp=7", wb_addr); end
    checks++; if (wb_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_wb_data got=%h exp=ffffff80", wb_data); end
  endtask

  task automatic test_back_to_back();
    rd_addr = 4; rd_data = 32'h55; rd_we = 1;
    tick();
    checks++; if (wb_data !== 32'h55 || wb_addr !== 5'd4 || wb_en !== 1'b1) begin
      failures++; $display("FAIL b2b_wb got=%h/%0d/%b exp=00000055/4/1", wb_data, wb_addr, wb_en); end
    idle_inputs();
  endtask

  task automatic test_load_hu();
    mem_addr = 32'h102; mem_rd = 1; rd_fmt = 5'b10000; rd_addr = 9;
    tick();
    idle_inputs();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'hBEEF_1234;
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL lhu_halt got=%b exp=1", halt); end
    tick();
    idle_inputs();
    checks++; if (wb_data !== 32'h0000_BEEF) begin failures++; $display("FAIL lhu_data got=%h exp=0000beef", wb_data); end
    checks++; if (wb_en !== 1'b1 || wb_addr !== 5'd9) begin failures++; $display("FAIL lhu_wb got=%b/%0d exp=1/9", wb_en, wb_addr); end
`ifndef MEM_MISALIGN_CHECK_EN
    // LH at byte 3 wraps to the upper halfword
    mem_addr = 32'h103; mem_rd = 1; rd_fmt = 5'b00010; rd_addr = 10;
    tick();
    idle_inputs();
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h8001_0000;
    tick();
    idle_inputs();
    checks++; if (wb_data !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_wrap got=%h exp=ffff8001", wb_data); end
`endif
  endtask

  task automatic test_store();
    mem_addr = 32'h201; mem_wr = 1; mem_wfmt = 3'b001; mem_wdata = 32'h1234_56AB; rd_addr = 3; rd_we = 1;
    tick();
    idle_inputs();
    checks++; if (dmem_if.dmem_we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", dmem_if.dmem_we); end
    checks++; if (dmem_if.dmem_be !== 4'b0010) begin failures++; $display("FAIL sb_be got=%b exp=0010", dmem_if.dmem_be); end
    checks++; if (dmem_if.dmem_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", dmem_if.dmem_wdata); end
    checks++; if (dmem_if.dmem_addr !== 32'h200) begin failures++; $display("FAIL sb_addr got=%h exp=00000200", dmem_if.dmem_addr); end
    dmem_if.dmem_ack = 1;
    tick();
    idle_inputs();
    checks++; if (wb_en !== 1'b0 || halt !== 1'b0) begin failures++; $display("FAIL sb_wb got=%b/%b exp=0/0", wb_en, halt); end
    mem_addr = 32'h202; mem_wr = 1; mem_wfmt = 3'b010; mem_wdata = 32'h0000_CAFE;
    tick();
    idle_inputs();
    checks++; if (dmem_if.dmem_be !== 4'b1100 || dmem_if.dmem_wdata !== 32'hCAFE_CAFE) begin
      failures++; $display("FAIL sh_lanes got=%b/%h exp=1100/cafecafe", dmem_if.dmem_be, dmem_if.dmem_wdata); end
    dmem_if.dmem_ack = 1;
    tick();
    idle_inputs();
    // read+write together: write wins
    mem_addr = 32'h300; mem_wr = 1; mem_rd = 1; mem_wfmt = 3'b100; rd_fmt = 5'b00100;
    mem_wdata = 32'hDEAD_BEEF; rd_addr = 12;
    tick();
    idle_inputs();
    checks++; if (dmem_if.dmem_we !== 1'b1 || dmem_if.dmem_be !== 4'b1111 || dmem_if.dmem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rw_both got=%b/%b/%h exp=1/1111/deadbeef", dmem_if.dmem_we, dmem_if.dmem_be, dmem_if.dmem_wdata); end
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h1111_1111;
    tick();
    idle_inputs();
    checks++; if (wb_en !== 1'b0) begin failures++; $display("FAIL rw_both_wb got=%b exp=0", wb_en); end
  endtask

  task automatic test_reset_mid_access();
    mem_addr = 32'h400; mem_rd = 1; rd_fmt = 5'b00100; rd_addr = 6;
    tick();
    idle_inputs();
    checks++; if (dmem_if.dmem_req !== 1'b1) begin failures++; $display("FAIL rma_req got=%b exp=1", dmem_if.dmem_req); end
    resetn = 0;
    tick();
    checks++; if (dmem_if.dmem_req !== 1'b0 || halt !== 1'b0) begin failures++; $display("FAIL rma_abort got=%b/%b exp=0/0", dmem_if.dmem_req, halt); end
    checks++; if (dmem_if.dmem_addr !== 32'h0 || wb_en !== 1'b0) begin failures++; $display("FAIL rma_clear got=%h/%b exp=0/0", dmem_if.dmem_addr, wb_en); end
    resetn = 1;
    dmem_if.dmem_ack = 1; dmem_if.dmem_rdata = 32'h1234_5678;
    tick();
    idle_inputs();
    tick();
    checks++; if (wb_en !== 1'b0 || dmem_if.dmem_req !== 1'b0 || halt !== 1'b0) begin
      failures++; $display("FAIL rma_late_ack got=%b/%b/%b exp=0/0/0", wb_en, dmem_if.dmem_req, halt); end
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign();
    mem_addr = 32'h102; mem_rd = 1; rd_fmt = 5'b00100; rd_addr = 8;
    tick();
    idle_inputs();
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", misalign); end
    checks++; if (dmem_if.dmem_req !== 1'b0 || halt !== 1'b0 || wb_en !== 1'b0) begin
      failures++; $display("FAIL mis_noreq got=%b/%b/%b exp=0/0/0", dmem_if.dmem_req, halt, wb_en); end
    tick();
    checks++; if (misalign !== 1'b0 || wb_en !== 1'b0) begin failures++; $display("FAIL mis_once got=%b/%b exp=0/0", misalign, wb_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte();
    test_back_to_back();
    test_load_hu();
    test_store();
    test_reset_mid_access();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
